sw_debounce: RTL and testbench
==============================

SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter DB_CYCLES, default 20000: consecutive clk edges a synchronised switch level must differ from the debounced value before it is accepted; legal range 1..2^CNT_W-1.
REQ-002 Parameter CNT_W, default 16: width of each per-bit debounce counter.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk; reset==0 resets the block.
REQ-005 sw  input  16  raw, asynchronous board switch levels.
REQ-006 switch_cs  input  1  switch-region read strobe from the address decoder; read-to-clear for sw_chg.
REQ-007 sw_out  output  16  debounced switch value; drives the switch path of the CPU read-data mux.
REQ-008 sw_chg  output  16  sticky per-bit change flags (REQ-018..021).
REQ-009 sw_irq  output  1  OR-reduction of sw_chg.

Function
REQ-010 Each sw bit SHALL pass through a two-flop synchroniser (s1, then s2) before any other logic uses it.
REQ-011 Each bit SHALL have its own CNT_W-bit counter cnt[i].
REQ-012 On any edge where s2[i]==sw_out[i]: cnt[i] SHALL load 0 and sw_out[i] SHALL hold.
REQ-013 On an edge where s2[i]!=sw_out[i] and cnt[i]!=DB_CYCLES-1: cnt[i] SHALL increment and sw_out[i] SHALL hold.
REQ-014 On an edge where s2[i]!=sw_out[i] and cnt[i]==DB_CYCLES-1: sw_out[i] SHALL load s2[i] and cnt[i] SHALL load 0.
REQ-015 Latency: if sw[i] holds a new level from the edge at which s1 first captures it (edge k), sw_out[i] SHALL change on edge k+1+DB_CYCLES.
REQ-016 A level held in s2 for fewer than DB_CYCLES consecutive differing edges SHALL NOT change sw_out[i]; its partial count is discarded.
REQ-017 Bits SHALL be fully independent; simultaneous transitions on several bits SHALL each obey REQ-012..015.
REQ-018 With SW_CHG_IRQ_EN defined, sw_chg[i] SHALL set on the edge where sw_out[i] toggles.
REQ-019 sw_chg SHALL clear to 0 on an edge where switch_cs==1.
REQ-020 If switch_cs==1 on the same edge that bit i toggles, sw_chg[i] SHALL end at 1 (set wins); other bits clear.
REQ-021 sw_irq SHALL equal |sw_chg, registered in the same cycle as sw_chg (no extra delay).
REQ-022 Counter overflow SHALL be impossible: cnt[i] SHALL never exceed DB_CYCLES-1.

Reset
REQ-023 With reset==0 at a clk edge: s1, s2, sw_out, every cnt[i], sw_chg and sw_irq SHALL all become 0.
REQ-024 Reset during a count SHALL abandon it; after release, a held non-zero switch SHALL reach sw_out with full REQ-015 latency measured from the first edge after release.
REQ-025 A sw_out 0->1 transition caused by REQ-024 SHALL set sw_chg like any other toggle.

Configuration
REQ-026 Macro SW_CHG_IRQ_EN: when defined, sw_chg/sw_irq SHALL behave per REQ-018..021.
REQ-027 When SW_CHG_IRQ_EN is undefined, sw_chg SHALL be constant 0, sw_irq constant 0, switch_cs ignored, and no flag registers synthesised; sw_out behaviour SHALL be unchanged.

Verification (DB_CYCLES=4, SW_CHG_IRQ_EN defined unless stated)
REQ-028 Reset low 2 cycles with sw=16'hFFFF -> sw_out=0, sw_chg=0, sw_irq=0; after release sw_out=16'hFFFF exactly 5 edges after the first post-release edge; sw_chg=16'hFFFF.
REQ-029 sw[3] 0->1 held -> sw_out[3]=1 at edge k+5; sw_chg=16'h0008; sw_irq=1.
REQ-030 sw[0] pulse high 3 cycles then low -> sw_out stays 16'h0000, sw_chg stays 0.
REQ-031 sw_chg=16'h0008, then switch_cs=1 on the same edge sw_out[5] toggles -> sw_chg=16'h0020, sw_irq=1; next switch_cs pulse -> sw_chg=0, sw_irq=0.
REQ-032 sw 16'h0000 -> 16'hA5A5 on one edge -> sw_out=16'hA5A5 at k+5, all eight bits on the same edge.
REQ-033 SW_CHG_IRQ_EN undefined, rerun REQ-029 -> sw_out identical, sw_chg=0, sw_irq=0 throughout.

Source files
------------

// File: rtl/sw_debounce.sv
// 16-bit switch synchroniser and debouncer with optional sticky change flags.
// Define SW_CHG_IRQ_EN to build sw_chg/sw_irq; otherwise both are tied to 0.
module sw_debounce #(
    parameter int DB_CYCLES = 20000,
    parameter int CNT_W     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sw,
    input  logic        switch_cs,
    output logic [15:0] sw_out,
    output logic [15:0] sw_chg,
    output logic        sw_irq
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [15:0] s1_q;
    logic [15:0] s2_q;
    logic [15:0] deb_val;
    logic [15:0] toggle;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= sw;
            s2_q <= s1_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bit
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             out_q;
            logic             out_d;
            logic             differ;
            logic             at_last;

            assign differ  = s2_q[gi] ^ out_q;
            assign at_last = (cnt_q == CNT_LAST);

            // Any agreeing edge discards the partial count.
            always_comb begin
                cnt_d = '0;
                out_d = out_q;
                if (differ) begin
                    if (at_last) begin
                        out_d = s2_q[gi];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    cnt_q <= '0;
                    out_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    out_q <= out_d;
                end
            end

            assign deb_val[gi] = out_q;
            assign toggle[gi]  = differ & at_last;
        end
    endgenerate

    assign sw_out = deb_val;

`ifdef SW_CHG_IRQ_EN
    logic [15:0] chg_q;
    logic [15:0] chg_d;
    logic        irq_q;

    // A toggle on the clearing edge survives the read.
    always_comb begin
        chg_d = (switch_cs ? 16'h0000 : chg_q) | toggle;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            chg_q <= '0;
            irq_q <= 1'b0;
        end else begin
            chg_q <= chg_d;
            irq_q <= |chg_d;
        end
    end

    assign sw_chg = chg_q;
    assign sw_irq = irq_q;
`else
    logic [16:0] unused_sigs;
    assign unused_sigs = {switch_cs, toggle};
    assign sw_chg      = '0;
    assign sw_irq      = 1'b0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce (DB_CYCLES=4): directed vector table plus random run
// against a sliding-window reference model.
module tb_sw_debounce;
    localparam int DB = 4;
    localparam int CW = 3;
`ifdef SW_CHG_IRQ_EN
    localparam bit CHG_EN = 1'b1;
`else
    localparam bit CHG_EN = 1'b0;
`endif

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        switch_cs = 1'b0;
    logic [15:0] sw        = 16'h0000;
    logic [15:0] sw_out;
    logic [15:0] sw_chg;
    logic        sw_irq;

    int n_cmp = 0;
    int n_bad = 0;

    sw_debounce #(.DB_CYCLES(DB), .CNT_W(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .sw       (sw),
        .switch_cs(switch_cs),
        .sw_out   (sw_out),
        .sw_chg   (sw_chg),
        .sw_irq   (sw_irq)
    );

    always #5 clk = ~clk;

    // Reference model: hist[0] is the switch sample taken at the latest edge.
    // A bit flips at edge e when the synchronised samples seen on the last DB
    // edges all differ from the output and no reset/flip happened inside them.
    logic [15:0] hist[$];
    logic [15:0] m_out = 16'h0000;
    logic [15:0] m_chg = 16'h0000;
    logic        m_irq = 1'b0;
    int          edge_no = 0;
    int          last_evt[16];

    task automatic model_edge(input logic [15:0] s, input logic cs, input logic rst_n);
        logic [15:0] tog;
        bit          all_diff;
        edge_no++;
        tog = '0;
        if (!rst_n) begin
            foreach (hist[j]) hist[j] = '0;
            for (int i = 0; i < 16; i++) last_evt[i] = edge_no;
            m_out = '0;
            m_chg = '0;
            m_irq = 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                all_diff = (edge_no - last_evt[i] >= DB);
                for (int j = 1; j <= DB; j++)
                    if (hist[j][i] === m_out[i]) all_diff = 1'b0;
                if (all_diff) begin
                    tog[i] = 1'b1;
                    last_evt[i] = edge_no;
                end
            end
            m_out = m_out ^ tog;
            if (CHG_EN) m_chg = (cs ? 16'h0000 : m_chg) | tog;
            m_irq = |m_chg;
            hist.push_front(s);
            void'(hist.pop_back());
        end
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [15:0] s, input logic cs, input logic rst_n);
        sw        = s;
        switch_cs = cs;
        reset     = rst_n;
        @(posedge clk);
        model_edge(s, cs, rst_n);
        #1;
        check("model sw_out", sw_out, m_out);
        check("model sw_chg", sw_chg, m_chg);
        check("model sw_irq", {15'b0, sw_irq}, {15'b0, m_irq});
    endtask

    typedef struct {
        logic        rst_n;
        logic [15:0] sw;
        logic        cs;
        int          hold;
        logic [15:0] e_out;
        logic [15:0] e_chg;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] e_chg;
    logic [15:0] r_sw;

    initial begin
        for (int i = 0; i < DB + 2; i++) hist.push_back(16'h0000);
        for (int i = 0; i < 16; i++) last_evt[i] = 0;

        // Reset with all switches high, then full latency after release.
        step(16'hFFFF, 1'b0, 1'b0);
        step(16'hFFFF, 1'b0, 1'b0);
        check("reset sw_out", sw_out, 16'h0000);
        check("reset sw_chg", sw_chg, 16'h0000);
        check("reset sw_irq", {15'b0, sw_irq}, 16'h0000);
        for (int k = 0; k <= DB; k++) begin
            step(16'hFFFF, 1'b0, 1'b1);
            check("release before k+5", sw_out, 16'h0000);
        end
        step(16'hFFFF, 1'b0, 1'b1);
        check("release at k+5 sw_out", sw_out, 16'hFFFF);
        check("release at k+5 sw_chg", sw_chg, CHG_EN ? 16'hFFFF : 16'h0000);
        check("release at k+5 sw_irq", {15'b0, sw_irq}, {15'b0, CHG_EN});

        tbl.push_back('{1'b1, 16'hFFFF, 1'b1, 1, 16'hFFFF, 16'h0000});
        tbl.push_back('{1'b1, 16'h0000, 1'b0, 5, 16'hFFFF, 16'h0000});
        tbl.push_back('{1'b1, 16'h0000, 1'b0, 1, 16'h0000, 16'hFFFF});
        tbl.push_back('{1'b1, 16'h0000, 1'b1, 1, 16'h0000, 16'h0000});
        tbl.push_back('{1'b1, 16'h0008, 1'b0, 5, 16'h0000, 16'h0000});
        tbl.push_back('{1'b1, 16'h0008, 1'b0, 1, 16'h0008, 16'h0008});
        tbl.push_back('{1'b1, 16'h0028, 1'b0, 5, 16'h0008, 16'h0008});
        tbl.push_back('{1'b1, 16'h0028, 1'b1, 1, 16'h0028, 16'h0020});
        tbl.push_back('{1'b1, 16'h0028, 1'b1, 1, 16'h0028, 16'h0000});
        tbl.push_back('{1'b1, 16'h0000, 1'b0, 5, 16'h0028, 16'h0000});
        tbl.push_back('{1'b1, 16'h0000, 1'b0, 1, 16'h0000, 16'h0028});
        tbl.push_back('{1'b1, 16'h0000, 1'b1, 1, 16'h0000, 16'h0000});
        tbl.push_back('{1'b1, 16'h0001, 1'b0, 3, 16'h0000, 16'h0000});
        tbl.push_back('{1'b1, 16'h0000, 1'b0, 6, 16'h0000, 16'h0000});
        tbl.push_back('{1'b1, 16'hA5A5, 1'b0, 5, 16'h0000, 16'h0000});
        tbl.push_back('{1'b1, 16'hA5A5, 1'b0, 1, 16'hA5A5, 16'hA5A5});
        tbl.push_back('{1'b1, 16'hA5A5, 1'b1, 1, 16'hA5A5, 16'h0000});
        tbl.push_back('{1'b1, 16'hFFFF, 1'b0, 3, 16'hA5A5, 16'h0000});
        tbl.push_back('{1'b0, 16'hFFFF, 1'b0, 1, 16'h0000, 16'h0000});
        tbl.push_back('{1'b1, 16'hFFFF, 1'b0, 5, 16'h0000, 16'h0000});
        tbl.push_back('{1'b1, 16'hFFFF, 1'b0, 1, 16'hFFFF, 16'hFFFF});

        foreach (tbl[r]) begin
            for (int h = 0; h < tbl[r].hold; h++) step(tbl[r].sw, tbl[r].cs, tbl[r].rst_n);
            e_chg = CHG_EN ? tbl[r].e_chg : 16'h0000;
            check($sformatf("vec%0d sw_out", r), sw_out, tbl[r].e_out);
            check($sformatf("vec%0d sw_chg", r), sw_chg, e_chg);
            check($sformatf("vec%0d sw_irq", r), {15'b0, sw_irq}, {15'b0, |e_chg});
            $display("vec%0d sw=%h cs=%b rst_n=%b hold=%0d -> sw_out=%h sw_chg=%h sw_irq=%b",
                     r, tbl[r].sw, tbl[r].cs, tbl[r].rst_n, tbl[r].hold, sw_out, sw_chg, sw_irq);
        end

        // Random bouncing switches: each bit flips with probability 1/16 per cycle.
        r_sw = 16'h0000;
        for (int c = 0; c < 3000; c++) begin
            r_sw = r_sw ^ (16'($urandom) & 16'($urandom) & 16'($urandom) & 16'($urandom));
            step(r_sw, ($urandom_range(0, 7) == 0), ($urandom_range(0, 399) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
